btn_debounce_multi: RTL and testbench

- Parametrised N-channel successor to the single-button debouncer.
- Each channel has its own 2-FF synchroniser, stability counter, registered clean level, one-cycle press/release pulses and a long-press/auto-repeat generator.
- Sits between raw board buttons and user logic; one instance serves a whole button bank on the 1 MHz system clock.

---
 rtl/btn_debounce_multi.sv | 159 +++++++++++++++
 tb/tb_btn_debounce_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: 2-FF synchroniser, stability debounce, registered
// clean level, press/release pulses and a long-press / auto-repeat pulse per channel.
module btn_debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16384,
    parameter int IDLE_LEVEL    = 0,
    parameter int LONG_CYCLES   = 1000000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_CYCLES = 200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btnIn,
    output logic [CHANNELS-1:0] btnOut,
    output logic [CHANNELS-1:0] pressPulse,
    output logic [CHANNELS-1:0] releasePulse,
    output logic [CHANNELS-1:0] longPulse
);

    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int LW = $clog2(LONG_CYCLES) + 1;
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam int HW = (LW > RW) ? LW : RW;

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES - 1);

    localparam logic                IDLE_BIT  = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;
    localparam logic [CHANNELS-1:0] IDLE_VEC  = {CHANNELS{IDLE_BIT}};
    localparam logic                REPEAT_ON = (REPEAT_EN != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] HS_IDLE      = 2'd0;
    localparam logic [1:0] HS_WAIT_LONG = 2'd1;
    localparam logic [1:0] HS_REPEAT    = 2'd2;
    localparam logic [1:0] HS_DONE      = 2'd3;

    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;
    logic [CHANNELS-1:0] btn_out_r;
    logic [CHANNELS-1:0] press_r;
    logic [CHANNELS-1:0] release_r;
    logic [CHANNELS-1:0] long_r;
    logic [SW-1:0]       stab_cnt_r   [CHANNELS];
    logic [HW-1:0]       hold_cnt_r   [CHANNELS];
    logic [1:0]          hold_state_r [CHANNELS];

    logic [CHANNELS-1:0] btn_out_s;
    logic [CHANNELS-1:0] accept_s;
    logic [CHANNELS-1:0] press_s;
    logic [CHANNELS-1:0] release_s;
    logic [CHANNELS-1:0] long_s;
    logic [SW-1:0]       stab_cnt_s   [CHANNELS];
    logic [HW-1:0]       hold_cnt_s   [CHANNELS];
    logic [1:0]          hold_state_s [CHANNELS];

    // Stability counter: accept the synchronised level after STABLE_CYCLES differing cycles
    always_comb begin
        btn_out_s = btn_out_r;
        accept_s  = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            stab_cnt_s[c] = {SW{1'b0}};
            if (sync2_r[c] == btn_out_r[c]) begin
                stab_cnt_s[c] = {SW{1'b0}};
            end else if (stab_cnt_r[c] == STABLE_LAST) begin
                btn_out_s[c] = sync2_r[c];
                accept_s[c]  = 1'b1;
            end else begin
                stab_cnt_s[c] = stab_cnt_r[c] + SW'(1'b1);
            end
        end
    end

    // Edge pulses and hold FSM; an acceptance always wins over a pending long pulse
    always_comb begin
        press_s   = {CHANNELS{1'b0}};
        release_s = {CHANNELS{1'b0}};
        long_s    = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            hold_cnt_s[c]   = hold_cnt_r[c];
            hold_state_s[c] = hold_state_r[c];
            if (accept_s[c] && (sync2_r[c] != IDLE_BIT)) begin
                press_s[c]      = 1'b1;
                hold_state_s[c] = HS_WAIT_LONG;
                hold_cnt_s[c]   = {HW{1'b0}};
            end else if (accept_s[c]) begin
                release_s[c]    = 1'b1;
                hold_state_s[c] = HS_IDLE;
                hold_cnt_s[c]   = {HW{1'b0}};
            end else if (btn_out_r[c] == IDLE_BIT) begin
                hold_state_s[c] = HS_IDLE;
                hold_cnt_s[c]   = {HW{1'b0}};
            end else begin
                case (hold_state_r[c])
                    HS_WAIT_LONG: begin
                        if (hold_cnt_r[c] == LONG_LAST) begin
                            long_s[c]       = 1'b1;
                            hold_cnt_s[c]   = {HW{1'b0}};
                            hold_state_s[c] = REPEAT_ON ? HS_REPEAT : HS_DONE;
                        end else begin
                            hold_cnt_s[c] = hold_cnt_r[c] + HW'(1'b1);
                        end
                    end
                    HS_REPEAT: begin
                        if (hold_cnt_r[c] == REPEAT_LAST) begin
                            long_s[c]     = 1'b1;
                            hold_cnt_s[c] = {HW{1'b0}};
                        end else begin
                            hold_cnt_s[c] = hold_cnt_r[c] + HW'(1'b1);
                        end
                    end
                    HS_DONE: begin
                        hold_cnt_s[c] = hold_cnt_r[c];
                    end
                    // Pressed while the FSM reads idle: park silently until release
                    default: begin
                        hold_state_s[c] = HS_DONE;
                        hold_cnt_s[c]   = {HW{1'b0}};
                    end
                endcase
            end
        end
    end

    // State registers with synchronous reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= IDLE_VEC;
            sync2_r   <= IDLE_VEC;
            btn_out_r <= IDLE_VEC;
            press_r   <= {CHANNELS{1'b0}};
            release_r <= {CHANNELS{1'b0}};
            long_r    <= {CHANNELS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                stab_cnt_r[c]   <= {SW{1'b0}};
                hold_cnt_r[c]   <= {HW{1'b0}};
                hold_state_r[c] <= HS_IDLE;
            end
        end else begin
            sync1_r   <= btnIn;
            sync2_r   <= sync1_r;
            btn_out_r <= btn_out_s;
            press_r   <= press_s;
            release_r <= release_s;
            long_r    <= long_s;
            for (int c = 0; c < CHANNELS; c++) begin
                stab_cnt_r[c]   <= stab_cnt_s[c];
                hold_cnt_r[c]   <= hold_cnt_s[c];
                hold_state_r[c] <= hold_state_s[c];
            end
        end
    end

    assign btnOut       = btn_out_r;
    assign pressPulse   = press_r;
    assign releasePulse = release_r;
    assign longPulse    = long_r;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: three instances (repeat on, repeat off, idle-high),
// timing expectations queued as events at drive time and checked every cycle.
module tb_btn_debounce_multi;

    localparam int ST = 4;
    localparam int LG = 20;
    localparam int RP = 8;

    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_LONG  = 2;
    localparam int EV_RST   = 3;

    typedef struct {
        int at;
        int dut;
        int ch;
        int kind;
    } ev_t;

    typedef struct {
        int         dut;
        logic [1:0] mask;
        int         len;
        int         lng0;
        int         lng1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in [3];
    logic [1:0] d_out  [3];
    logic [1:0] d_pr   [3];
    logic [1:0] d_rl   [3];
    logic [1:0] d_lg   [3];

    logic [1:0] idle_v  [3] = '{2'b00, 2'b00, 2'b11};
    int         rep_en  [3] = '{1, 0, 0};
    logic [1:0] exp_lvl [3] = '{2'b00, 2'b00, 2'b11};
    logic [1:0] e_p [3];
    logic [1:0] e_r [3];
    logic [1:0] e_l [3];
    int         long_cnt [3][2];

    ev_t sb[$];
    int  edge_n = 0;
    int  checks = 0;
    int  errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    btn_debounce_multi #(.CHANNELS(2), .STABLE_CYCLES(ST), .IDLE_LEVEL(0), .LONG_CYCLES(LG),
                         .REPEAT_EN(1), .REPEAT_CYCLES(RP)) dut_rep (
        .clk(clk), .rst(rst), .btnIn(btn_in[0]), .btnOut(d_out[0]),
        .pressPulse(d_pr[0]), .releasePulse(d_rl[0]), .longPulse(d_lg[0]));

    btn_debounce_multi #(.CHANNELS(2), .STABLE_CYCLES(ST), .IDLE_LEVEL(0), .LONG_CYCLES(LG),
                         .REPEAT_EN(0), .REPEAT_CYCLES(RP)) dut_norep (
        .clk(clk), .rst(rst), .btnIn(btn_in[1]), .btnOut(d_out[1]),
        .pressPulse(d_pr[1]), .releasePulse(d_rl[1]), .longPulse(d_lg[1]));

    btn_debounce_multi #(.CHANNELS(2), .STABLE_CYCLES(ST), .IDLE_LEVEL(1), .LONG_CYCLES(LG),
                         .REPEAT_EN(0), .REPEAT_CYCLES(RP)) dut_inv (
        .clk(clk), .rst(rst), .btnIn(btn_in[2]), .btnOut(d_out[2]),
        .pressPulse(d_pr[2]), .releasePulse(d_rl[2]), .longPulse(d_lg[2]));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, d, edge_n, act, exp);
        end
    endtask

    task automatic push(input int at, input int d, input int c, input int kind);
        sb.push_back('{at: at, dut: d, ch: c, kind: kind});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Press the masked channels for len cycles, queueing every pulse the spec implies
    task automatic hold_btn(input int d, input logic [1:0] mask, input int len);
        int k;
        int r;
        int t;
        k = edge_n + 1;
        r = k + len;
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                push(k + ST + 1, d, c, EV_PRESS);
                push(r + ST + 1, d, c, EV_REL);
                t = k + ST + 1 + LG;
                while (t < r + ST + 1) begin
                    push(t, d, c, EV_LONG);
                    if (rep_en[d] == 0) break;
                    t += RP;
                end
            end
        end
        btn_in[d] = idle_v[d] ^ mask;
        repeat (len) step();
        btn_in[d] = idle_v[d];
    endtask

    // Monitor: apply events due this cycle, then compare all outputs of all instances
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 3; d++) begin
                    e_p[d] = 2'b00;
                    e_r[d] = 2'b00;
                    e_l[d] = 2'b00;
                end
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    ev = sb[i];
                    if (ev.at == edge_n) begin
                        case (ev.kind)
                            EV_PRESS: begin
                                exp_lvl[ev.dut][ev.ch] = ~idle_v[ev.dut][ev.ch];
                                e_p[ev.dut][ev.ch] = 1'b1;
                            end
                            EV_REL: begin
                                exp_lvl[ev.dut][ev.ch] = idle_v[ev.dut][ev.ch];
                                e_r[ev.dut][ev.ch] = 1'b1;
                            end
                            EV_LONG: e_l[ev.dut][ev.ch] = 1'b1;
                            default: exp_lvl[ev.dut] = idle_v[ev.dut];
                        endcase
                        sb.delete(i);
                    end else if (ev.at < edge_n) begin
                        chk("stale_event", ev.dut, ev.at, edge_n);
                        sb.delete(i);
                    end
                end
                for (int d = 0; d < 3; d++) begin
                    chk("btnOut", d, d_out[d], exp_lvl[d]);
                    chk("pressPulse", d, d_pr[d], e_p[d]);
                    chk("releasePulse", d, d_rl[d], e_r[d]);
                    chk("longPulse", d, d_lg[d], e_l[d]);
                    for (int c = 0; c < 2; c++)
                        if (d_lg[d][c] === 1'b1) long_cnt[d][c]++;
                end
            end
        end
    end

    initial begin
        vec_t       vecs [9];
        logic [7:0] bounce_pat;
        int         k;
        int         n1;
        int         l0;
        int         l1;

        vecs[0] = '{0, 2'b01, 10, 0, 0};
        vecs[1] = '{0, 2'b01,  4, 0, 0};
        vecs[2] = '{0, 2'b10, 50, 0, 4};
        vecs[3] = '{0, 2'b10, 28, 0, 1};
        vecs[4] = '{0, 2'b11, 36, 2, 2};
        vecs[5] = '{1, 2'b10, 50, 0, 1};
        vecs[6] = '{1, 2'b11, 20, 0, 0};
        vecs[7] = '{1, 2'b11, 21, 1, 1};
        vecs[8] = '{2, 2'b01, 30, 1, 0};
        bounce_pat = 8'b0111_0111;

        for (int d = 0; d < 3; d++) begin
            btn_in[d] = idle_v[d];
            for (int c = 0; c < 2; c++) long_cnt[d][c] = 0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 9; i++) begin
            l0 = long_cnt[vecs[i].dut][0];
            l1 = long_cnt[vecs[i].dut][1];
            hold_btn(vecs[i].dut, vecs[i].mask, vecs[i].len);
            repeat (12) step();
            chk("long_count_ch0", vecs[i].dut, long_cnt[vecs[i].dut][0] - l0, vecs[i].lng0);
            chk("long_count_ch1", vecs[i].dut, long_cnt[vecs[i].dut][1] - l1, vecs[i].lng1);
        end

        // Bounce shorter than the stability window: no events queued
        for (int i = 0; i < 8; i++) begin
            btn_in[0][0] = bounce_pat[i];
            step();
        end
        btn_in[0] = 2'b00;
        repeat (12) step();

        // Reset while channel 0 is held and already accepted
        k = edge_n + 1;
        push(k + ST + 1, 0, 0, EV_PRESS);
        btn_in[0] = 2'b01;
        repeat (8) step();
        rst = 1'b1;
        n1 = edge_n + 1;
        for (int d = 0; d < 3; d++) push(n1, d, 0, EV_RST);
        step();
        rst = 1'b0;
        push(n1 + 1 + ST + 1, 0, 0, EV_PRESS);
        repeat (10) step();
        k = edge_n + 1;
        push(k + ST + 1, 0, 0, EV_REL);
        btn_in[0] = 2'b00;
        repeat (12) step();

        chk("pending_events", 0, sb.size(), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
